fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and defaults for the instruction fetch unit.
// Revision: 1.0
`default_nettype none

package fetch_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam addr_t C_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer of {pc, instr} with push/pop/flush and count.
// Revision: 1.0
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int    DEPTH    = 2,
  parameter addr_t RESET_PC = C_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [31:0]              i_push_pc,
  input  logic [31:0]              i_push_data,
  input  logic                     i_pop,
  output logic [31:0]              o_head_pc,
  output logic [31:0]              o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  addr_t           r_pc   [DEPTH];
  word_t           r_data [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;

  // Storage is reset so the head reads {RESET_PC, 0} straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= RESET_PC;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_pc[r_wr]   <= i_push_pc;
        r_data[r_wr] <= i_push_data;
        r_wr         <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head_pc   = r_pc[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with buffered decode handoff and redirect flush.
// Optional macro FETCH_PERF_EN adds perf_delivered / perf_flushed counters. Revision: 1.0
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC = C_RESET_PC,
  parameter int    DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e         r_state;
  state_e         w_state_nxt;
  addr_t          r_fetch_pc;
  addr_t          w_fetch_pc_nxt;
  logic           r_pend;
  addr_t          r_pend_pc;
  logic [CW-1:0]  w_count;
  logic [CW:0]    w_occ;
  logic           w_pop;
  logic           w_push;
  logic           w_req;
  logic           w_unused_bits;

  assign w_unused_bits = ^redirect_pc[1:0];

  assign w_pop = inst_valid && inst_ready;

  // Occupancy after this cycle's transfer, so a steady stream needs no bubbles.
  assign w_occ = {1'b0, w_count} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_pend};

  assign w_req  = rst_n && (r_state == FETCH) && !redirect_valid &&
                  (w_occ < (CW+1)'(DEPTH));
  assign w_push = r_pend && !redirect_valid;

  always_comb begin
    w_state_nxt    = FETCH;
    w_fetch_pc_nxt = r_fetch_pc;
    if (w_req) begin
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end
    if (redirect_valid) begin
      w_state_nxt    = DROP;
      w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend     <= w_req;
      if (w_req) begin
        r_pend_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_pc   (r_pend_pc),
    .i_push_data (imem_rdata),
    .i_pop       (w_pop),
    .o_head_pc   (inst_pc),
    .o_head_data (inst_data),
    .o_count     (w_count)
  );

  assign imem_req   = w_req;
  assign imem_addr  = {2'b00, r_fetch_pc[31:2]};
  assign inst_valid = (w_count != '0);
  assign inst_pc4   = inst_pc + 32'd4;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_delivered;
  logic [31:0] r_perf_flushed;
  logic [31:0] w_flush_n;

  // Entries lost to a redirect: what remains after the transfer plus the response in flight.
  assign w_flush_n = 32'(w_count) - 32'(w_pop) + 32'(r_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_delivered <= '0;
      r_perf_flushed   <= '0;
    end else begin
      if (w_pop) begin
        r_perf_delivered <= r_perf_delivered + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + w_flush_n;
      end
    end
  end

  assign perf_delivered = r_perf_delivered;
  assign perf_flushed   = r_perf_flushed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, hand sequences and randomized run against a queue-based fetch model.
// Revision: 1.0
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, inst_pc4;
  logic        w_imem_req, w_inst_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_inst_data, w_inst_pc, w_inst_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_delivered, perf_flushed, w_perf_delivered, w_perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc4(inst_pc4)
`ifdef FETCH_PERF_EN
    , .perf_delivered(perf_delivered), .perf_flushed(perf_flushed)
`endif
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_data(w_inst_data),
    .inst_pc(w_inst_pc), .inst_pc4(w_inst_pc4)
`ifdef FETCH_PERF_EN
    , .perf_delivered(w_perf_delivered), .perf_flushed(w_perf_flushed)
`endif
  );

  // Memory word n holds value n; garbage when no request was made.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? imem_addr   : 32'hDEAD_BEEF;
    w_imem_rdata <= w_imem_req ? w_imem_addr : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: buffered pcs, in-flight pcs, next fetch pc, cycles still blocked.
  logic [31:0] m_buf[$];
  logic [31:0] m_fly[$];
  logic [31:0] m_fetch = 32'h0;
  int          m_wait = 1;
  logic [31:0] m_deliv = 32'h0;
  logic [31:0] m_flush = 32'h0;
  bit          m_live = 1'b0;
  logic        m_pop = 1'b0;
  logic        m_req = 1'b0;

  task automatic apply(input logic rn, input logic rdy, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst_n = rn; inst_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    #1;
    m_pop = 1'b0;
    m_req = 1'b0;
    if (m_live) begin
      m_pop = (m_buf.size() > 0) && rdy;
      m_req = rn && (m_wait == 0) && !rv &&
              ((m_buf.size() - int'(m_pop) + m_fly.size()) < DEPTH);
      chk("model.imem_req", imem_req, m_req);
      chk("model.imem_addr", imem_addr, m_fetch >> 2);
      chk("model.inst_valid", inst_valid, m_buf.size() > 0);
      if (m_buf.size() > 0) begin
        chk("model.inst_pc", inst_pc, m_buf[0]);
        chk("model.inst_data", inst_data, m_buf[0] >> 2);
        chk("model.inst_pc4", inst_pc4, m_buf[0] + 32'd4);
      end
`ifdef FETCH_PERF_EN
      chk("model.perf_delivered", perf_delivered, m_deliv);
      chk("model.perf_flushed", perf_flushed, m_flush);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_buf.delete(); m_fly.delete();
      m_fetch = 32'h0; m_wait = 1; m_deliv = 0; m_flush = 0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_pop) begin
        void'(m_buf.pop_front());
        m_deliv = m_deliv + 32'd1;
      end
      if (redirect_valid) begin
        m_flush = m_flush + 32'(m_buf.size() + m_fly.size());
        m_buf.delete(); m_fly.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_wait  = 1;
      end else begin
        foreach (m_fly[i]) m_buf.push_back(m_fly[i]);
        m_fly.delete();
        if (m_req) begin
          m_fly.push_back(m_fetch);
          m_fetch = m_fetch + 32'd4;
        end
        if (m_wait > 0) m_wait--;
      end
    end
  endtask

  task automatic cycle(input logic rn, input logic rdy, input logic rv, input logic [31:0] rp);
    apply(rn, rdy, rv, rp);
    tick();
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rp;
    logic        ev;
    logic        ereq;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    // Cycle 0 is the first cycle with rst_n high; ready held high throughout.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h8};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h43, 1'b1, 1'b0, 32'h40};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h40};
    tbl[14] = '{1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0};
    tbl[18] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC0};
    tbl[19] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC4};

    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst.imem_req", imem_req, 32'h0);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk("rst.inst_valid", inst_valid, 32'h0);
    chk("rst.inst_data", inst_data, 32'h0);
    chk("rst.inst_pc", inst_pc, 32'h0);
    chk("rst.inst_pc4", inst_pc4, 32'h4);
    chk("rst_w.imem_addr", w_imem_addr, 32'h3FFF_FFFE);
    chk("rst_w.inst_pc", w_inst_pc, WRAP_PC);
    chk("rst_w.inst_pc4", w_inst_pc4, 32'hFFFF_FFFC);
    chk("rst_w.inst_valid", w_inst_valid, 32'h0);
    tick();

    for (int k = 0; k < 20; k++) begin
      apply(1'b1, tbl[k].rdy, tbl[k].rv, tbl[k].rp);
      chk($sformatf("tbl[%0d].inst_valid", k), inst_valid, tbl[k].ev);
      chk($sformatf("tbl[%0d].imem_req", k), imem_req, tbl[k].ereq);
      if (tbl[k].ev) begin
        chk($sformatf("tbl[%0d].inst_pc", k), inst_pc, tbl[k].epc);
        chk($sformatf("tbl[%0d].inst_data", k), inst_data, tbl[k].epc >> 2);
      end
      if (k >= 3 && k <= 5) begin
        chk($sformatf("wrap[%0d].valid", k), w_inst_valid, 32'h1);
        chk($sformatf("wrap[%0d].pc", k), w_inst_pc, WRAP_PC + 32'(4 * (k - 3)));
        chk($sformatf("wrap[%0d].pc4", k), w_inst_pc4, WRAP_PC + 32'(4 * (k - 2)));
        chk($sformatf("wrap[%0d].data", k), w_inst_data, (WRAP_PC + 32'(4 * (k - 3))) >> 2);
      end
      tick();
    end

    // Stall: exactly DEPTH requests, head pc 0 held, then an in-order drain.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    nreq = 0;
    for (int j = 0; j < 14; j++) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0);
      nreq += int'(imem_req);
      if (j >= 4) begin
        chk("stall.inst_valid", inst_valid, 32'h1);
        chk("stall.inst_pc", inst_pc, 32'h0);
        chk("stall.imem_req", imem_req, 32'h0);
      end
      tick();
    end
    chk("stall.req_count", 32'(nreq), 32'(DEPTH));
    for (int j = 0; j < 8; j++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0);
      chk("drain.inst_valid", inst_valid, 32'h1);
      chk("drain.inst_pc", inst_pc, 32'(4 * j));
      tick();
    end

`ifdef FETCH_PERF_EN
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 8; j++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h100);
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    chk("perf.delivered", perf_delivered, 32'd5);
    chk("perf.flushed", perf_flushed, 32'd2);
    tick();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf.rst_delivered", perf_delivered, 32'd0);
    chk("perf.rst_flushed", perf_flushed, 32'd0);
    tick();
`endif

    for (int j = 0; j < 3000; j++) begin
      logic        rn, rdy, rv;
      logic [31:0] rp;
      rn  = ($urandom_range(63) != 0);
      rdy = ($urandom_range(9) < 7);
      rv  = ($urandom_range(15) == 0);
      rp  = ($urandom_range(3) == 0) ? 32'($urandom_range(255)) : $urandom();
      cycle(rn, rdy, rv, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
